// File: rtl/posit_stream_decoder.sv
// Streaming posit<8,0> field decoder: scans the regime one bit per clock and
// presents sign, regime scale k, hidden-bit fraction and zero/NaR flags.
module posit_stream_decoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_posit,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sign,
  output logic [5:0] out_k,
  output logic [6:0] out_frac,
  output logic       out_z,
  output logic       out_inf
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  state_e     state_q, state_d;
  logic [6:0] sh_q, sh_d;
  logic [2:0] run_q, run_d;
  logic       rc_q, rc_d;
  logic       sign_q, sign_d;

  logic       out_sign_q, out_sign_d;
  logic [5:0] out_k_q, out_k_d;
  logic [6:0] out_frac_q, out_frac_d;
  logic       out_z_q, out_z_d;
  logic       out_inf_q, out_inf_d;

  logic [6:0] payload;
  logic [6:0] payload_abs;
  logic [6:0] sh_shift;
  logic [2:0] run_fin;
  logic       scan_done;

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    run_d      = run_q;
    rc_d       = rc_q;
    sign_d     = sign_q;
    out_sign_d = out_sign_q;
    out_k_d    = out_k_q;
    out_frac_d = out_frac_q;
    out_z_d    = out_z_q;
    out_inf_d  = out_inf_q;

    payload     = in_posit[6:0];
    payload_abs = in_posit[7] ? (~payload + 7'd1) : payload;
    sh_shift    = {sh_q[5:0], 1'b0};
    run_fin     = run_q;
    scan_done   = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d = in_posit[7];
          sh_d   = payload_abs;
          rc_d   = payload_abs[6];
          run_d  = '0;
          if (payload == '0) begin
            state_d    = DONE;
            out_sign_d = in_posit[7];
            out_k_d    = '0;
            out_frac_d = '0;
            out_z_d    = ~in_posit[7];
            out_inf_d  = in_posit[7];
          end else begin
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        sh_d = sh_shift;
        if (sh_q[6] == rc_q) begin
          run_d   = run_q + 3'd1;
          // Seven matching bits means the regime filled the whole payload.
          if (run_q == 3'd6) begin
            run_fin   = 3'd7;
            scan_done = 1'b1;
          end
        end else begin
          scan_done = 1'b1;
        end
        if (scan_done) begin
          state_d    = DONE;
          out_sign_d = sign_q;
          out_k_d    = rc_q ? ({3'b000, run_fin} - 6'd1) : (6'd0 - {3'b000, run_fin});
          out_frac_d = {1'b1, sh_shift[6:1]};
          out_z_d    = 1'b0;
          out_inf_d  = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      sh_q       <= '0;
      run_q      <= '0;
      rc_q       <= 1'b0;
      sign_q     <= 1'b0;
      out_sign_q <= 1'b0;
      out_k_q    <= '0;
      out_frac_q <= '0;
      out_z_q    <= 1'b0;
      out_inf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      run_q      <= run_d;
      rc_q       <= rc_d;
      sign_q     <= sign_d;
      out_sign_q <= out_sign_d;
      out_k_q    <= out_k_d;
      out_frac_q <= out_frac_d;
      out_z_q    <= out_z_d;
      out_inf_q  <= out_inf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sign  = out_sign_q;
  assign out_k     = out_k_q;
  assign out_frac  = out_frac_q;
  assign out_z     = out_z_q;
  assign out_inf   = out_inf_q;

endmodule

// File: tb/tb_posit_stream_decoder.sv
// Scoreboard bench for posit_stream_decoder: a reference field decoder feeds
// an expectation queue that is drained as results are transferred out.
module tb_posit_stream_decoder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_posit;
  logic       out_valid;
  logic       out_ready;
  logic       out_sign;
  logic [5:0] out_k;
  logic [6:0] out_frac;
  logic       out_z;
  logic       out_inf;

  posit_stream_decoder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_posit (in_posit),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sign (out_sign),
    .out_k    (out_k),
    .out_frac (out_frac),
    .out_z    (out_z),
    .out_inf  (out_inf)
  );

  typedef struct {
    logic [7:0] w;
    logic       s;
    logic [5:0] k;
    logic [6:0] f;
    logic       z;
    logic       inf;
    int         lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Reference decode: count the regime run directly on the magnitude payload.
  function automatic exp_t model(input logic [7:0] w);
    exp_t        e;
    logic [6:0]  pp;
    logic [13:0] t;
    logic        rc;
    logic        stop;
    int          r;
    e.w = w; e.s = w[7]; e.z = 1'b0; e.inf = 1'b0;
    if (w[6:0] == 7'd0) begin
      e.k = '0; e.f = '0; e.z = ~w[7]; e.inf = w[7]; e.lat = 0;
      return e;
    end
    pp   = w[7] ? 7'(8'd128 - {1'b0, w[6:0]}) : w[6:0];
    rc   = pp[6];
    r    = 0;
    stop = 1'b0;
    for (int i = 6; i >= 0; i--) begin
      if (!stop && pp[i] == rc) r++;
      else stop = 1'b1;
    end
    e.k   = rc ? 6'(r - 1) : 6'(-r);
    t     = 14'(pp) << (r + 1);
    e.f   = {1'b1, t[6:1]};
    e.lat = (r + 1 < 7) ? r + 1 : 7;
    return e;
  endfunction

  task automatic check_fields(input string tag, input exp_t e);
    check_eq({tag, ".sign"}, 32'(out_sign), 32'(e.s));
    check_eq({tag, ".k"},    32'(out_k),    32'(e.k));
    check_eq({tag, ".frac"}, 32'(out_frac), 32'(e.f));
    check_eq({tag, ".z"},    32'(out_z),    32'(e.z));
    check_eq({tag, ".inf"},  32'(out_inf),  32'(e.inf));
  endtask

  // Called at a sample point (#1 after a rising edge) with the DUT idle.
  task automatic decode_one(input logic [7:0] w, input int stall);
    exp_t e;
    int   n;
    string tag;
    tag = $sformatf("w%02h", w);
    in_valid = 1'b1;
    in_posit = w;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check_eq({tag, ".accept_timeout"}, 32'(n >= 20), 32'd0);
    exp_q.push_back(model(w));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq({tag, ".busy_ready"}, 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    e = exp_q.pop_front();
    check_eq({tag, ".latency"}, 32'(n), 32'(e.lat));
    // Offer another word while stalled; it must not be taken.
    in_valid = 1'b1;
    in_posit = 8'hAA;
    for (int c = 0; c < stall; c++) begin
      @(posedge clk); #1;
      check_eq({tag, ".stall_valid"}, 32'(out_valid), 32'd1);
      check_eq({tag, ".stall_ready"}, 32'(in_ready), 32'd0);
      check_eq({tag, ".stall_k"},     32'(out_k),    32'(e.k));
      check_eq({tag, ".stall_frac"},  32'(out_frac), 32'(e.f));
    end
    in_valid = 1'b0;
    check_fields(tag, e);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq({tag, ".post_valid"}, 32'(out_valid), 32'd0);
    check_eq({tag, ".post_ready"}, 32'(in_ready),  32'd1);
    check_eq({tag, ".hold_k"},     32'(out_k),     32'(e.k));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_posit  = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst.in_ready",  32'(in_ready),  32'd1);
    check_eq("rst.out_valid", 32'(out_valid), 32'd0);
    check_eq("rst.sign",      32'(out_sign),  32'd0);
    check_eq("rst.k",         32'(out_k),     32'd0);
    check_eq("rst.frac",      32'(out_frac),  32'd0);
    check_eq("rst.z",         32'(out_z),     32'd0);
    check_eq("rst.inf",       32'(out_inf),   32'd0);
    rst_n = 1'b1;

    decode_one(8'h40, 0);
    decode_one(8'h50, 1);
    decode_one(8'h60, 0);
    decode_one(8'h20, 0);
    decode_one(8'h7F, 0);
    decode_one(8'h01, 2);
    decode_one(8'hC0, 0);
    decode_one(8'hFF, 0);
    decode_one(8'h81, 0);
    decode_one(8'h7E, 0);
    decode_one(8'h00, 0);
    decode_one(8'h80, 0);
    decode_one(8'h3C, 5);

    // Asynchronous reset in the middle of a long regime scan.
    in_valid = 1'b1;
    in_posit = 8'h7F;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst.out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst.in_ready",  32'(in_ready),  32'd1);
    check_eq("midrst.k",         32'(out_k),     32'd0);
    check_eq("midrst.frac",      32'(out_frac),  32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    decode_one(8'h40, 0);

    for (int v = 0; v < 256; v++) begin
      decode_one(8'(v), int'($urandom_range(0, 2)));
    end

    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
